// File: rtl/skin_bbox_tracker.sv
// Per-frame bounding box and pixel count of a 1-bit skin mask stream.
// Frames chain automatically once aligned by iSOF; the input is never stalled.
module skin_bbox_tracker #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter int unsigned MIN_COUNT = 64,
  parameter int unsigned CW        = 10
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          iSOF,
  input  logic          iDATA,
  input  logic          iDVAL,
  output logic          oVALID,
  output logic          oFOUND,
  output logic [CW-1:0] oX_MIN,
  output logic [CW-1:0] oX_MAX,
  output logic [CW-1:0] oY_MIN,
  output logic [CW-1:0] oY_MAX,
  output logic [16:0]   oCOUNT
);

  localparam logic [0:0] StWaitSof = 1'b0;
  localparam logic [0:0] StActive  = 1'b1;

  localparam logic [CW-1:0] XLast  = CW'(H_RES - 1);
  localparam logic [CW-1:0] YLast  = CW'(V_RES - 1);
  localparam logic [16:0]   CntMax = '1;
  localparam logic [16:0]   MinCnt = 17'(MIN_COUNT);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [16:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d, found_q, found_d;
  logic [CW-1:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
  logic [CW-1:0] oy_min_q, oy_min_d, oy_max_q, oy_max_d;
  logic [16:0]   count_q, count_d;

  // Base values after an optional iSOF, so a coincident pixel lands on (0,0).
  logic [CW-1:0] b_col, b_row, b_xmin, b_xmax, b_ymin, b_ymax;
  logic [16:0]   b_cnt, p_cnt;
  logic [CW-1:0] p_xmin, p_xmax, p_ymin, p_ymax;
  logic          take, hit, last, found;

  always_comb begin
    b_col  = iSOF ? '0    : col_q;
    b_row  = iSOF ? '0    : row_q;
    b_xmin = iSOF ? XLast : xmin_q;
    b_xmax = iSOF ? '0    : xmax_q;
    b_ymin = iSOF ? YLast : ymin_q;
    b_ymax = iSOF ? '0    : ymax_q;
    b_cnt  = iSOF ? '0    : cnt_q;

    take = iDVAL && (iSOF || (state_q == StActive));
    hit  = take && iDATA;
    last = take && (b_col == XLast) && (b_row == YLast);

    p_cnt  = (hit && (b_cnt != CntMax)) ? b_cnt + 17'd1 : b_cnt;
    p_xmin = (hit && (b_col < b_xmin)) ? b_col : b_xmin;
    p_xmax = (hit && (b_col > b_xmax)) ? b_col : b_xmax;
    p_ymin = (hit && (b_row < b_ymin)) ? b_row : b_ymin;
    p_ymax = (hit && (b_row > b_ymax)) ? b_row : b_ymax;
    found  = p_cnt >= MinCnt;

    state_d = iSOF ? StActive : state_q;
    col_d   = b_col;
    row_d   = b_row;
    xmin_d  = b_xmin;
    xmax_d  = b_xmax;
    ymin_d  = b_ymin;
    ymax_d  = b_ymax;
    cnt_d   = b_cnt;

    valid_d  = 1'b0;
    found_d  = found_q;
    ox_min_d = ox_min_q;
    ox_max_d = ox_max_q;
    oy_min_d = oy_min_q;
    oy_max_d = oy_max_q;
    count_d  = count_q;

    if (take) begin
      if (b_col == XLast) begin
        col_d = '0;
        row_d = (b_row == YLast) ? '0 : b_row + 1'b1;
      end else begin
        col_d = b_col + 1'b1;
      end
      xmin_d = p_xmin;
      xmax_d = p_xmax;
      ymin_d = p_ymin;
      ymax_d = p_ymax;
      cnt_d  = p_cnt;
    end

    if (last) begin
      xmin_d   = XLast;
      xmax_d   = '0;
      ymin_d   = YLast;
      ymax_d   = '0;
      cnt_d    = '0;
      valid_d  = 1'b1;
      found_d  = found;
      ox_min_d = found ? p_xmin : '0;
      ox_max_d = found ? p_xmax : '0;
      oy_min_d = found ? p_ymin : '0;
      oy_max_d = found ? p_ymax : '0;
      count_d  = p_cnt;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q  <= StWaitSof;
      col_q    <= '0;
      row_q    <= '0;
      xmin_q   <= XLast;
      xmax_q   <= '0;
      ymin_q   <= YLast;
      ymax_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      found_q  <= 1'b0;
      ox_min_q <= '0;
      ox_max_q <= '0;
      oy_min_q <= '0;
      oy_max_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      found_q  <= found_d;
      ox_min_q <= ox_min_d;
      ox_max_q <= ox_max_d;
      oy_min_q <= oy_min_d;
      oy_max_q <= oy_max_d;
      count_q  <= count_d;
    end
  end

  assign oVALID = valid_q;
  assign oFOUND = found_q;
  assign oX_MIN = ox_min_q;
  assign oX_MAX = ox_max_q;
  assign oY_MIN = oy_min_q;
  assign oY_MAX = oy_max_q;
  assign oCOUNT = count_q;

endmodule

// File: tb/tb_skin_bbox_tracker.sv
// Bench for skin_bbox_tracker on a reduced 24x16 frame, two thresholds sharing one stream.
module tb_skin_bbox_tracker;

  localparam int H    = 24;
  localparam int V    = 16;
  localparam int CW   = 10;
  localparam int NPix = H * V;
  localparam int MinA = 1;
  localparam int MinB = 8;

  logic iclk = 1'b0;
  logic irst, iSOF, iDATA, iDVAL;
  logic va, fa, vb, fb;
  logic [CW-1:0] xa0, xa1, ya0, ya1, xb0, xb1, yb0, yb1;
  logic [16:0] ca, cb;

  always #5 iclk = ~iclk;

  skin_bbox_tracker #(.H_RES(H), .V_RES(V), .MIN_COUNT(MinA), .CW(CW)) u_dut_a (
    .iclk(iclk), .irst(irst), .iSOF(iSOF), .iDATA(iDATA), .iDVAL(iDVAL),
    .oVALID(va), .oFOUND(fa), .oX_MIN(xa0), .oX_MAX(xa1), .oY_MIN(ya0), .oY_MAX(ya1),
    .oCOUNT(ca)
  );

  skin_bbox_tracker #(.H_RES(H), .V_RES(V), .MIN_COUNT(MinB), .CW(CW)) u_dut_b (
    .iclk(iclk), .irst(irst), .iSOF(iSOF), .iDATA(iDATA), .iDVAL(iDVAL),
    .oVALID(vb), .oFOUND(fb), .oX_MIN(xb0), .oX_MAX(xb1), .oY_MIN(yb0), .oY_MAX(yb1),
    .oCOUNT(cb)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: linear pixel index since frame start plus list of skin coordinates.
  bit          m_active;
  int          m_pos;
  int          skin_x[$];
  int          skin_y[$];
  bit          e_valid;
  logic [57:0] hold_a, hold_b;

  typedef struct {
    int x0, x1, y0, y1, gap;
    int cnt, bx0, bx1, by0, by1;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [57:0] mk(int t, int cnt, int x0, int x1, int y0, int y1);
    bit f;
    logic [CW-1:0] a, b, c, d;
    f = cnt >= t;
    a = f ? CW'(x0) : '0;
    b = f ? CW'(x1) : '0;
    c = f ? CW'(y0) : '0;
    d = f ? CW'(y1) : '0;
    return {f, a, b, c, d, 17'(cnt)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_report();
    int cnt, x0, x1, y0, y1;
    cnt = skin_x.size();
    if (cnt > 131071) cnt = 131071;
    x0 = H - 1; x1 = 0; y0 = V - 1; y1 = 0;
    foreach (skin_x[i]) begin
      if (skin_x[i] < x0) x0 = skin_x[i];
      if (skin_x[i] > x1) x1 = skin_x[i];
      if (skin_y[i] < y0) y0 = skin_y[i];
      if (skin_y[i] > y1) y1 = skin_y[i];
    end
    hold_a = mk(MinA, cnt, x0, x1, y0, y1);
    hold_b = mk(MinB, cnt, x0, x1, y0, y1);
  endtask

  task automatic model_step(bit sof, bit dval, bit data);
    e_valid = 1'b0;
    if (sof) begin
      m_active = 1'b1;
      m_pos    = 0;
      skin_x.delete();
      skin_y.delete();
    end
    if (m_active && dval) begin
      if (data) begin
        skin_x.push_back(m_pos % H);
        skin_y.push_back(m_pos / H);
      end
      if (m_pos == NPix - 1) begin
        model_report();
        e_valid = 1'b1;
        m_pos   = 0;
        skin_x.delete();
        skin_y.delete();
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic cyc(bit sof, bit dval, bit data);
    iSOF = sof; iDVAL = dval; iDATA = data;
    @(posedge iclk);
    model_step(sof, dval, data);
    @(negedge iclk);
    check("cycle_a", 64'({va, fa, xa0, xa1, ya0, ya1, ca}), 64'({e_valid, hold_a}));
    check("cycle_b", 64'({vb, fb, xb0, xb1, yb0, yb1, cb}), 64'({e_valid, hold_b}));
    if (va) pulses++;
  endtask

  task automatic pix(bit data, int gap);
    while (int'($urandom_range(99)) < gap) cyc(1'b0, 1'b0, 1'($urandom_range(1)));
    cyc(1'b0, 1'b1, data);
  endtask

  task automatic run_rect(int x0, int x1, int y0, int y1, int gap, int from);
    for (int i = from; i < NPix; i++) begin
      pix((i % H >= x0) && (i % H <= x1) && (i / H >= y0) && (i / H <= y1), gap);
    end
  endtask

  task automatic do_reset();
    irst = 1'b1;
    #1;
    check("reset_async", 64'({va, fa, xa0, xa1, ya0, ya1, ca}), 64'd0);
    m_active = 1'b0; m_pos = 0; skin_x.delete(); skin_y.delete();
    hold_a = '0; hold_b = '0; e_valid = 1'b0;
    iSOF = 1'b0; iDVAL = 1'b1; iDATA = 1'b1;
    @(posedge iclk);
    @(posedge iclk);
    @(negedge iclk);
    irst = 1'b0;
    check("reset_b", 64'({vb, fb, xb0, xb1, yb0, yb1, cb}), 64'd0);
  endtask

  initial begin
    int p0;
    irst = 1'b1; iSOF = 1'b0; iDVAL = 1'b0; iDATA = 1'b0;
    vecs[0] = '{x0: 5,  x1: 5,  y0: 7,  y1: 7,  gap: 0,  cnt: 1,   bx0: 5,  bx1: 5,  by0: 7, by1: 7};
    vecs[1] = '{x0: 1,  x1: 0,  y0: 0,  y1: 0,  gap: 0,  cnt: 0,   bx0: 0,  bx1: 0,  by0: 0, by1: 0};
    vecs[2] = '{x0: 10, x1: 14, y0: 3,  y1: 6,  gap: 40, cnt: 20,  bx0: 10, bx1: 14, by0: 3, by1: 6};
    vecs[3] = '{x0: 0,  x1: 6,  y0: 15, y1: 15, gap: 10, cnt: 7,   bx0: 0,  bx1: 6,  by0: 15, by1: 15};
    vecs[4] = '{x0: 16, x1: 23, y0: 0,  y1: 0,  gap: 10, cnt: 8,   bx0: 16, bx1: 23, by0: 0, by1: 0};
    vecs[5] = '{x0: 0,  x1: 23, y0: 0,  y1: 15, gap: 0,  cnt: 384, bx0: 0,  bx1: 23, by0: 0, by1: 15};

    #2;
    do_reset();

    // Pixels before any iSOF are ignored.
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1);

    cyc(1'b1, 1'b0, 1'b0);
    foreach (vecs[k]) begin
      run_rect(vecs[k].x0, vecs[k].x1, vecs[k].y0, vecs[k].y1, vecs[k].gap, 0);
      check($sformatf("tbl%0d_a", k), 64'({va, fa, xa0, xa1, ya0, ya1, ca}),
            64'({1'b1, mk(MinA, vecs[k].cnt, vecs[k].bx0, vecs[k].bx1, vecs[k].by0, vecs[k].by1)}));
      check($sformatf("tbl%0d_b", k), 64'({vb, fb, xb0, xb1, yb0, yb1, cb}),
            64'({1'b1, mk(MinB, vecs[k].cnt, vecs[k].bx0, vecs[k].bx1, vecs[k].by0, vecs[k].by1)}));
    end

    // Partial frame discarded; iSOF+iDVAL+iDATA counts (0,0); then only (20,12).
    p0 = pulses;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) pix(i == H + 10, 20);
    cyc(1'b1, 1'b1, 1'b1);
    check("partial_no_valid", 64'(pulses), 64'(p0));
    run_rect(20, 20, 12, 12, 20, 1);
    check("sof_frame_a", 64'({va, fa, xa0, xa1, ya0, ya1, ca}),
          64'({1'b1, mk(MinA, 2, 0, 20, 0, 12)}));

    // iSOF on the last pixel wins: no report, that pixel becomes (0,0).
    for (int i = 0; i < NPix - 1; i++) pix(1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1);
    check("sof_last_no_valid", 64'(va), 64'd0);
    run_rect(1, 0, 0, 0, 0, 1);
    check("sof_last_next_a", 64'({va, fa, xa0, xa1, ya0, ya1, ca}),
          64'({1'b1, mk(MinA, 1, 0, 0, 0, 0)}));

    // Reset mid-frame, pixels without iSOF, then three back-to-back frames.
    for (int i = 0; i < 50; i++) pix(1'b1, 0);
    @(negedge iclk);
    #2;
    do_reset();
    p0 = pulses;
    for (int i = 0; i < NPix + 10; i++) cyc(1'b0, 1'b1, 1'b1);
    check("no_valid_before_sof", 64'(pulses), 64'(p0));
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * NPix; i++) cyc(1'b0, 1'b1, 1'($urandom_range(3) == 0));
    check("back_to_back_pulses", 64'(pulses - p0), 64'd3);

    // Random density, gaps and rare mid-frame iSOF, checked every cycle by the model.
    for (int f = 0; f < 6; f++) begin
      int dens;
      dens = int'($urandom_range(100));
      for (int i = 0; i < NPix; i++) begin
        if ($urandom_range(799) == 0) cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        else pix(int'($urandom_range(99)) < dens, 30);
      end
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
